ase_fifo_rr_drain: RTL and testbench

Round-robin drain scheduler that shares one downstream channel among NUM_REQ FIFOs built to the team's standard FIFO read protocol. That protocol is: registered `empty`, `rd_en` gated internally against underflow, and `data_out_v`/`data_out` one cycle after `rd_en`. The block issues reads, tracks the in-flight read, and forwards returned words with their source index. Grants follow a bounded-burst round-robin policy. Downstream almost-full backpressure is honored. Reads that return no data, because the FIFO's registered `empty` was stale, are tolerated and counted.

---
 rtl/ase_fifo_rr_drain_if.sv | 28 ++
 rtl/ase_fifo_rr_drain.sv | 167 ++++++++++++++++
 tb/tb_ase_fifo_rr_drain.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ase_fifo_rr_drain_if.sv
// Signal bundle between the round-robin drain scheduler, its source FIFOs and
// the shared downstream channel.
interface ase_fifo_rr_drain_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int SRC_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]            fifo_empty;
   logic [NUM_REQ-1:0]            fifo_rd_en;
   logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data_out;
   logic [NUM_REQ-1:0]            fifo_data_out_v;
   logic                          out_alm_full;
   logic                          out_valid;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [SRC_W-1:0]              out_src;
   logic [15:0]                   miss_cnt;
   logic                          err_proto;

   modport master (
      input  fifo_empty, fifo_data_out, fifo_data_out_v, out_alm_full,
      output fifo_rd_en, out_valid, out_data, out_src, miss_cnt, err_proto
   );

   modport slave (
      output fifo_empty, fifo_data_out, fifo_data_out_v, out_alm_full,
      input  fifo_rd_en, out_valid, out_data, out_src, miss_cnt, err_proto
   );
endinterface

// File: rtl/ase_fifo_rr_drain.sv
// Bounded-burst round-robin drain of NUM_REQ FIFOs onto one downstream channel,
// tracking the single in-flight read and counting reads that return nothing.
module ase_fifo_rr_drain #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 4,
   parameter int SRC_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   ase_fifo_rr_drain_if.master bus
);
   localparam int BURST_W = ($clog2(MAX_BURST) > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   logic [1:0]            rst_sync_q, rst_sync_d;
   logic                  rst_int_n;
   logic [1:0]            state_q, state_d;
   logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]      cur_q, cur_d;
   logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic                  pend_v_q, pend_v_d;
   logic [SRC_W-1:0]      pend_src_q, pend_src_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [SRC_W-1:0]      out_src_q, out_src_d;
   logic [15:0]           miss_cnt_q, miss_cnt_d;
   logic                  err_q, err_d;

   logic [SRC_W-1:0]      idx;
   logic [SRC_W-1:0]      winner;
   logic                  any_elig;
   logic                  rd_issue;
   logic [NUM_REQ-1:0]    rd_en;
   logic [NUM_REQ-1:0]    pend_onehot;
   logic                  hit;
   logic                  stray;

   // NOTE: reset asserts asynchronously but releases through two flops, so no
   // state flop ever sees rst removal close to a clock edge.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_int_n = rst_sync_q[1];

   // NOTE: every signal gets a default at the top of each always_comb so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      idx      = '0;
      winner   = '0;
      any_elig = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!any_elig && !bus.fifo_empty[idx]) begin
            any_elig = 1'b1;
            winner   = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cur_d       = cur_q;
      burst_cnt_d = burst_cnt_q;
      rd_issue    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!bus.out_alm_full && any_elig) begin
               cur_d       = winner;
               burst_cnt_d = '0;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            rd_issue = !bus.fifo_empty[cur_q] && !bus.out_alm_full;
            if (rd_issue) burst_cnt_d = burst_cnt_q + 1'b1;
            if (bus.out_alm_full) begin
               state_d = ST_STALL;
            end else if (bus.fifo_empty[cur_q] || (rd_issue && burst_cnt_q == BURST_LAST)) begin
               rr_ptr_d = SRC_W'((int'(cur_q) + 1) % NUM_REQ);
               state_d  = ST_IDLE;
            end
         end
         ST_STALL: begin
            if (!bus.out_alm_full) state_d = ST_GRANT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Raw rst_n also gates the strobe so no read escapes before the
   // synchronised reset reaches the state flops.
   always_comb begin
      rd_en = '0;
      if (rd_issue && rst_n) rd_en[cur_q] = 1'b1;
      pend_v_d   = |rd_en;
      pend_src_d = cur_q;
   end

   assign bus.fifo_rd_en = rd_en;

   always_comb begin
      pend_onehot             = '0;
      pend_onehot[pend_src_q] = 1'b1;
      hit   = pend_v_q && bus.fifo_data_out_v[pend_src_q];
      stray = pend_v_q ? |(bus.fifo_data_out_v & ~pend_onehot) : |bus.fifo_data_out_v;
      err_d       = err_q | stray;
      out_valid_d = hit && !stray;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (out_valid_d) begin
         out_data_d = bus.fifo_data_out[int'(pend_src_q)*DATA_WIDTH +: DATA_WIDTH];
         out_src_d  = pend_src_q;
      end
      // A stale empty flag turns a read into a no-data return; count, don't flag.
      miss_cnt_d = miss_cnt_q;
      if (pend_v_q && !bus.fifo_data_out_v[pend_src_q] && miss_cnt_q != 16'hFFFF)
         miss_cnt_d = miss_cnt_q + 16'd1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         cur_q       <= '0;
         burst_cnt_q <= '0;
         pend_v_q    <= 1'b0;
         pend_src_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         miss_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cur_q       <= cur_d;
         burst_cnt_q <= burst_cnt_d;
         pend_v_q    <= pend_v_d;
         pend_src_q  <= pend_src_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         miss_cnt_q  <= miss_cnt_d;
         err_q       <= err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.miss_cnt  = miss_cnt_q;
   assign bus.err_proto = err_q;
endmodule

// File: tb/tb_ase_fifo_rr_drain.sv
// Self-checking bench for ase_fifo_rr_drain: FIFO models feed random words and a
// round-robin drain-order model predicts the output stream.
module tb_ase_fifo_rr_drain;
   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 64;
   localparam int MAX_BURST  = 4;
   localparam int SRC_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DEPTH      = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic alm = 1'b0;
   logic [NUM_REQ-1:0] inj_v = '0;

   always #5 clk = ~clk;

   ase_fifo_rr_drain_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .SRC_W(SRC_W)) bus ();

   ase_fifo_rr_drain #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .SRC_W(SRC_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // FIFO models: registered empty, underflow-gated read, data valid one cycle later.
   logic [DATA_WIDTH-1:0]         mem [NUM_REQ][DEPTH];
   int                            wr_ptr [NUM_REQ];
   int                            rd_ptr [NUM_REQ];
   bit                            stale [NUM_REQ];
   logic [NUM_REQ-1:0]            empty_r;
   logic [NUM_REQ-1:0]            v_r;
   logic [NUM_REQ*DATA_WIDTH-1:0] data_r;

   assign bus.fifo_empty      = empty_r;
   assign bus.fifo_data_out   = data_r;
   assign bus.fifo_data_out_v = v_r | inj_v;
   assign bus.out_alm_full    = alm;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         empty_r <= '1;
         v_r     <= '0;
         data_r  <= '0;
         for (int i = 0; i < NUM_REQ; i++) rd_ptr[i] <= wr_ptr[i];
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.fifo_rd_en[i] && (wr_ptr[i] - rd_ptr[i]) > 0) begin
               data_r[i*DATA_WIDTH +: DATA_WIDTH] <= mem[i][rd_ptr[i] % DEPTH];
               v_r[i]     <= 1'b1;
               rd_ptr[i]  <= rd_ptr[i] + 1;
               empty_r[i] <= stale[i] ? 1'b0 : ((wr_ptr[i] - rd_ptr[i]) == 1);
            end else begin
               v_r[i]     <= 1'b0;
               empty_r[i] <= (wr_ptr[i] == rd_ptr[i]);
            end
         end
      end
   end

   // Monitors: cycle counter, read log (posedge) and output log (negedge).
   int                    cyc;
   int                    rd_cyc[$];
   int                    rd_src[$];
   int                    out_cyc[$];
   int                    out_src_l[$];
   logic [DATA_WIDTH-1:0] out_dat[$];

   always @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++)
         if (bus.fifo_rd_en[i]) begin
            rd_cyc.push_back(cyc);
            rd_src.push_back(i);
         end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (bus.out_valid) begin
         out_cyc.push_back(cyc);
         out_src_l.push_back(int'(bus.out_src));
         out_dat.push_back(bus.out_data);
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model state: per-source expected words and the predicted drain order.
   logic [DATA_WIDTH-1:0] ref_q [NUM_REQ][$];
   int                    ld_cnt [NUM_REQ];
   int                    model_ptr;
   int                    exp_src[$];
   logic [DATA_WIDTH-1:0] exp_dat[$];
   int                    exp_gap[$];
   int                    log_base;

   task automatic hold_reset();
      rst_n = 1'b0;
      alm   = 1'b0;
      inj_v = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stale[i] = 1'b0;
         ref_q[i].delete();
      end
      exp_src.delete();
      exp_dat.delete();
      exp_gap.delete();
      model_ptr = 0;
   endtask

   task automatic do_reset();
      hold_reset();
      tick(3);
      rst_n = 1'b1;
      tick(4);
   endtask

   // Push ld_cnt[i] random words into each FIFO and predict the drain order:
   // bursts of min(MAX_BURST, remaining) from the first non-empty source at or
   // after the pointer, the pointer then moving past the granted source.
   task automatic load_and_expect(input bit gaps);
      int rem [NUM_REQ];
      int w;
      int n;
      int prev_len;
      bit first;
      logic [DATA_WIDTH-1:0] word;
      exp_src.delete();
      exp_dat.delete();
      exp_gap.delete();
      log_base = out_cyc.size();
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < ld_cnt[i]; j++) begin
            word = {$urandom, $urandom};
            mem[i][wr_ptr[i] % DEPTH] = word;
            wr_ptr[i]++;
            ref_q[i].push_back(word);
         end
         rem[i] = ref_q[i].size();
      end
      first = 1'b1;
      prev_len = 0;
      forever begin
         w = -1;
         for (int k = 0; k < NUM_REQ; k++)
            if (w < 0 && rem[(model_ptr + k) % NUM_REQ] > 0) w = (model_ptr + k) % NUM_REQ;
         if (w < 0) break;
         n = (rem[w] < MAX_BURST) ? rem[w] : MAX_BURST;
         for (int j = 0; j < n; j++) begin
            exp_src.push_back(w);
            exp_dat.push_back(ref_q[w].pop_front());
            if (!gaps)      exp_gap.push_back(0);
            else if (j > 0) exp_gap.push_back(1);
            else if (first) exp_gap.push_back(0);
            else            exp_gap.push_back((prev_len == MAX_BURST) ? 2 : 3);
         end
         rem[w] -= n;
         first = 1'b0;
         prev_len = n;
         model_ptr = (w + 1) % NUM_REQ;
      end
   endtask

   task automatic wait_and_score(input string tag, input int bound);
      int got;
      int lim;
      for (int c = 0; c < bound && (out_cyc.size() - log_base) < exp_src.size(); c++) tick(1);
      tick(8);
      got = out_cyc.size() - log_base;
      check({tag, "_words"}, 64'(got), 64'(exp_src.size()));
      lim = (got < exp_src.size()) ? got : exp_src.size();
      for (int k = 0; k < lim; k++) begin
         check($sformatf("%s_src%0d", tag, k), 64'(out_src_l[log_base + k]), 64'(exp_src[k]));
         check($sformatf("%s_dat%0d", tag, k), out_dat[log_base + k], exp_dat[k]);
         if (exp_gap[k] != 0)
            check($sformatf("%s_gap%0d", tag, k),
                  64'(out_cyc[log_base + k] - out_cyc[log_base + k - 1]), 64'(exp_gap[k]));
      end
   endtask

   function automatic int count_rd(input int src, input int lo, input int hi);
      int n = 0;
      for (int k = 0; k < rd_cyc.size(); k++)
         if (rd_src[k] == src && rd_cyc[k] >= lo && rd_cyc[k] <= hi) n++;
      return n;
   endfunction

   function automatic int first_rd(input int src, input int lo);
      for (int k = 0; k < rd_cyc.size(); k++)
         if (rd_src[k] == src && rd_cyc[k] >= lo) return rd_cyc[k];
      return -1;
   endfunction

   function automatic int count_out(input int lo, input int hi);
      int n = 0;
      for (int k = 0; k < out_cyc.size(); k++)
         if (out_cyc[k] >= lo && out_cyc[k] <= hi) n++;
      return n;
   endfunction

   initial begin
      int ta, td, c0, n_rd, rd_base;
      for (int i = 0; i < NUM_REQ; i++) wr_ptr[i] = 0;
      hold_reset();
      tick(3);
      check("rst_rd_en",     64'(bus.fifo_rd_en), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_data",  bus.out_data, 64'(0));
      check("rst_out_src",   64'(bus.out_src), 64'(0));
      check("rst_miss_cnt",  64'(bus.miss_cnt), 64'(0));
      check("rst_err_proto", 64'(bus.err_proto), 64'(0));
      rst_n = 1'b1;
      tick(4);

      // Fairness with 10 words per source, then with random fill levels.
      for (int i = 0; i < NUM_REQ; i++) ld_cnt[i] = 10;
      load_and_expect(1'b1);
      wait_and_score("fair", 400);
      check("fair_miss", 64'(bus.miss_cnt), 64'(0));
      check("fair_err",  64'(bus.err_proto), 64'(0));

      do_reset();
      for (int i = 0; i < NUM_REQ; i++) ld_cnt[i] = $urandom_range(0, 10);
      load_and_expect(1'b1);
      wait_and_score("rand", 400);
      check("rand_miss", 64'(bus.miss_cnt), 64'(0));

      // Source 2 with a late empty flag: one extra read returns nothing.
      do_reset();
      stale[2] = 1'b1;
      rd_base = cyc;
      ld_cnt = '{0, 0, 3, 0};
      load_and_expect(1'b1);
      wait_and_score("stale", 100);
      check("stale_rd_pulses", 64'(count_rd(2, rd_base, cyc)), 64'(4));
      check("stale_miss", 64'(bus.miss_cnt), 64'(1));
      check("stale_err",  64'(bus.err_proto), 64'(0));

      // Backpressure after two reads of source 1; source 3 proves the rotation.
      do_reset();
      rd_base = cyc;
      ld_cnt = '{0, 8, 0, 2};
      load_and_expect(1'b0);
      for (c0 = 0; c0 < 50 && count_rd(1, rd_base, cyc) < 2; c0++) tick(1);
      check("bp_reached_2_reads", 64'(count_rd(1, rd_base, cyc)), 64'(2));
      alm = 1'b1;
      ta = cyc;
      tick(5);
      alm = 1'b0;
      td = cyc;
      n_rd = count_rd(0, ta, td - 1) + count_rd(1, ta, td - 1) +
             count_rd(2, ta, td - 1) + count_rd(3, ta, td - 1);
      check("bp_stall_reads", 64'(n_rd), 64'(0));
      check("bp_extra_le1", 64'(count_out(ta + 1, td - 1) <= 1), 64'(1));
      wait_and_score("bp", 200);
      check("bp_resume_cycle", 64'(first_rd(1, td)), 64'(td + 1));
      check("bp_resume_reads", 64'(count_rd(1, td, td + 3)), 64'(2));

      // Skip empty sources: pointer at 1, only source 3 loaded, then back to 0.
      do_reset();
      ld_cnt = '{1, 0, 0, 0};
      load_and_expect(1'b0);
      wait_and_score("skip_a", 100);
      ld_cnt = '{0, 0, 0, 1};
      load_and_expect(1'b0);
      wait_and_score("skip_b", 100);
      ld_cnt = '{1, 1, 0, 0};
      load_and_expect(1'b0);
      wait_and_score("skip_c", 100);

      // Reset mid-burst with the pointer moved to 1 beforehand.
      do_reset();
      ld_cnt = '{1, 0, 0, 0};
      load_and_expect(1'b0);
      wait_and_score("mid_pre", 100);
      rd_base = cyc;
      ld_cnt = '{0, 10, 0, 0};
      load_and_expect(1'b0);
      for (c0 = 0; c0 < 50 && count_rd(1, rd_base, cyc) < 2; c0++) tick(1);
      check("mid_in_burst", 64'(count_rd(1, rd_base, cyc) >= 2), 64'(1));
      hold_reset();
      #1;
      check("mid_rd_en_now",     64'(bus.fifo_rd_en), 64'(0));
      check("mid_out_valid_now", 64'(bus.out_valid), 64'(0));
      c0 = cyc;
      tick(3);
      rst_n = 1'b1;
      tick(6);
      check("mid_no_out_after", 64'(count_out(c0 + 1, cyc)), 64'(0));
      check("mid_miss",  64'(bus.miss_cnt), 64'(0));
      check("mid_err",   64'(bus.err_proto), 64'(0));
      check("mid_rd_en", 64'(bus.fifo_rd_en), 64'(0));
      ld_cnt = '{1, 1, 0, 0};
      load_and_expect(1'b0);
      wait_and_score("mid_post", 100);

      // Stray data-valid with nothing pending.
      do_reset();
      inj_v = 4'b0010;
      tick(1);
      inj_v = '0;
      check("perr_set",       64'(bus.err_proto), 64'(1));
      check("perr_out_valid", 64'(bus.out_valid), 64'(0));
      tick(3);
      check("perr_held", 64'(bus.err_proto), 64'(1));
      ld_cnt = '{3, 0, 0, 0};
      load_and_expect(1'b1);
      wait_and_score("perr_traffic", 100);
      check("perr_still_held", 64'(bus.err_proto), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
